mux_nx1_stream: RTL and testbench

//  Parametrised N-to-1, W-bit streaming multiplexer; successor to the 4x1 n-bit

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_nx1_stream.sv | 126 ++++++++++++
 tb/tb_mux_nx1_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode codes, lock state encoding and helpers for mux_nx1_stream
package mux_pkg;

    localparam logic [1:0] MODE_RR     = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_FORCED = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Reserved mode 3 behaves as round-robin, so anything not fixed/forced
    // advances the round-robin pointer.
    function automatic logic uses_rr(input logic [1:0] mode);
        return (mode != MODE_FIXED) && (mode != MODE_FORCED);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search from ptr upward with wrap
// Ports:
//   req         in  N      request vector
//   ptr         in  SEL_W  index where the search starts
//   grant       out SEL_W  index of the first requester at or after ptr
//   grant_valid out 1      some request was found
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    int               idx;
    logic [SEL_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int off = 0; off < N; off++) begin
            idx  = (int'(ptr) + off) % N;
            cand = SEL_W'(idx);
            if (!grant_valid && req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - N-to-1 W-bit streaming mux with registered output and selectable arbitration
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_data  [N*W]      channel i data at [i*W +: W]
//   in_valid [N]        channel i has a beat
//   in_ready [N]        channel i beat accepted this cycle (one-hot or 0)
//   mode     [2]        0 round-robin, 1 fixed priority (low wins), 2 forced by s, 3 as 0
//   s        [SEL_W]    forced channel index (mode 2 only)
//   out_data/out_valid/out_ready/out_sel  registered output beat and its source channel
// Optional MUX_NX1_STREAM_LAST_LOCK_EN: adds in_last [N] / out_last and a lock FSM that
//   keeps the grant on one channel until a beat with in_last=1 is accepted.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] s,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    output logic [SEL_W-1:0] out_sel
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W-1:0] grant;
    logic [N-1:0]     eligible;
    logic             grant_valid;
    logic             accept;
    logic             take;
    logic [W-1:0]     chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan_data[i] = in_data[i*W +: W];
    end

`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
    lock_state_t      state;
    lock_state_t      state_next;
    logic [SEL_W-1:0] lock_ch;
`endif

    // Fixed priority reuses the round-robin search with the start pinned at 0.
    // Forced and locked grants reduce the eligible set to a single channel,
    // so the start point no longer matters there. A shift past N-1 yields an
    // empty mask, which is how s >= N produces no grant.
    always_comb begin
        eligible = in_valid;
        arb_ptr  = rr_ptr;
        if (mode == MODE_FIXED) begin
            arb_ptr = '0;
        end else if (mode == MODE_FORCED) begin
            eligible = in_valid & (N'(1) << s);
        end
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
        if (state == ST_LOCKED) begin
            eligible = in_valid & (N'(1) << lock_ch);
        end
`endif
    end

    rr_arbiter #(.N(N)) u_arb (
        .req         (eligible),
        .ptr         (arb_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept   = !out_valid || out_ready;
    assign take     = accept && grant_valid && rst_n;
    assign in_ready = take ? (N'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= chan_data[grant];
                out_sel  <= grant;
                if (uses_rr(mode)) begin
                    rr_ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
    always_comb begin
        state_next = state;
        if (take) begin
            state_next = in_last[grant] ? ST_IDLE : ST_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                lock_ch  <= grant;
                out_last <= in_last[grant];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb/tb_mux_nx1_stream.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_mux_nx1_stream;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*W-1:0]   in_data = '0;
    logic [N-1:0]     in_valid = '0;
    logic [N-1:0]     in_ready;
    logic [1:0]       mode = 2'd0;
    logic [SEL_W-1:0] s = '0;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [SEL_W-1:0] out_sel;
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
    logic [N-1:0]     in_last = '1;
    logic             out_last;
`endif

    always #5 clk = ~clk;

    mux_nx1_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s         (s),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_sel   (out_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit   m_valid;
    logic [W-1:0] m_data;
    int   m_sel;
    int   m_ptr;
    bit   m_locked;
    int   m_lock_ch;
    bit   m_last;

    function automatic int model_grant();
        int start;
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 2'd2) return (int'(s) < N && in_valid[s]) ? int'(s) : -1;
        start = (mode == 2'd1) ? 0 : m_ptr;
        for (int k = 0; k < N; k++)
            if (in_valid[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] model_ready();
        int g;
        g = model_grant();
        if (rst_n && (!m_valid || out_ready) && g >= 0) return 32'(1) << g;
        return 32'd0;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
            m_locked = 0; m_lock_ch = 0; m_last = 0;
        end else if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = W'(in_data >> (g * W));
                m_sel   = g;
                if (mode != 2'd1 && mode != 2'd2) m_ptr = (g + 1) % N;
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
                m_last    = in_last[g];
                m_locked  = !in_last[g];
                m_lock_ch = g;
`endif
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic model_cycle();
        #1;
        check("rand_in_ready", in_ready, model_ready());
        model_edge();
        @(posedge clk); #1;
        check("rand_out_valid", out_valid, m_valid);
        check("rand_out_sel", out_sel, m_sel);
        check("rand_out_data", out_data, m_data);
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
        check("rand_out_last", out_last, m_last);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  s;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_sel;
        logic [3:0]  exp_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // forced select sweep, data A=A B=5 C=0 D=F
        vecs.push_back('{2'd2, 2'd0, 4'hF, 16'hF05A, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA});
        vecs.push_back('{2'd2, 2'd1, 4'hF, 16'hF05A, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h5});
        vecs.push_back('{2'd2, 2'd2, 4'hF, 16'hF05A, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h0});
        vecs.push_back('{2'd2, 2'd3, 4'hF, 16'hF05A, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hF});
        // round-robin rotation; forced grants above left the pointer at 0
        vecs.push_back('{2'd0, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA});
        vecs.push_back('{2'd0, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
        vecs.push_back('{2'd0, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC});
        vecs.push_back('{2'd0, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD});
        vecs.push_back('{2'd0, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA});
        // fixed priority
        vecs.push_back('{2'd1, 2'd0, 4'hA, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
        vecs.push_back('{2'd1, 2'd0, 4'hA, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
        vecs.push_back('{2'd1, 2'd0, 4'h8, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD});
        // forced onto an idle channel: no grant, output drains
        vecs.push_back('{2'd2, 2'd0, 4'hE, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0});
        // reserved mode acts as round-robin, pointer still 1
        vecs.push_back('{2'd3, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB});
        vecs.push_back('{2'd3, 2'd0, 4'hF, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC});
        vecs.push_back('{2'd0, 2'd0, 4'h0, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0});

        @(posedge clk); #1;
        do_reset();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 4'h0);
        check("reset_out_sel", out_sel, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            mode = vecs[i].mode; s = vecs[i].s; in_valid = vecs[i].valid;
            in_data = vecs[i].data; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_out_sel", i), out_sel, vecs[i].exp_sel);
                check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            end
        end

        // backpressure: first beat held for 3 stalled cycles, then no bubble
        do_reset();
        mode = 2'd0; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b0;
        #1; check("bp_first_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        check("bp_first_valid", out_valid, 1'b1);
        check("bp_first_sel", out_sel, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1; check("bp_stall_ready", in_ready, 4'b0000);
            @(posedge clk); #1;
            check("bp_stall_valid", out_valid, 1'b1);
            check("bp_stall_sel", out_sel, 2'd0);
            check("bp_stall_data", out_data, 4'hA);
        end
        out_ready = 1'b1;
        #1; check("bp_release_ready", in_ready, 4'b0010);
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 1'b1);
        check("bp_release_sel", out_sel, 2'd1);
        check("bp_release_data", out_data, 4'hB);

        // reset while a beat is held
        rst_n = 1'b0;
        #1; check("rst_mid_in_ready", in_ready, 4'b0000);
        @(posedge clk); #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_data", out_data, 4'h0);
        check("rst_mid_sel", out_sel, 2'd0);
        rst_n = 1'b1;
        #1; check("rst_after_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        check("rst_after_sel", out_sel, 2'd0);
        check("rst_after_data", out_data, 4'hA);

`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
        // ch1 packet of 3 beats holds the grant although ch2 waits
        do_reset();
        mode = 2'd0; in_valid = 4'b0110; in_data = 16'hDCBA; out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_last = {1'b1, 1'b0, (b == 2), 1'b1};
            #1; check("lock_in_ready", in_ready, 4'b0010);
            @(posedge clk); #1;
            check("lock_out_sel", out_sel, 2'd1);
            check("lock_out_last", out_last, (b == 2));
        end
        #1; check("lock_release_ready", in_ready, 4'b0100);
        @(posedge clk); #1;
        check("lock_release_sel", out_sel, 2'd2);
        check("lock_release_last", out_last, 1'b0);
`endif

        // randomized run against the reference model
        for (int c = 0; c < 800; c++) begin
            rst_n     = (c == 0) ? 1'b0 : (($urandom % 50) != 0);
            mode      = 2'($urandom_range(0, 3));
            s         = SEL_W'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = (($urandom % 4) != 0);
`ifdef MUX_NX1_STREAM_LAST_LOCK_EN
            in_last   = N'($urandom) | N'($urandom);
`endif
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
